fir_job_sequencer: RTL and testbench
====================================

Name: fir_job_sequencer

Overview:
Sequences one FIR job across the tap buffer, datapath and streamer.
- Latches a job descriptor: tap, input and output base addresses plus output length.
- Issues the streamer transfer requests in a fixed order, counts output handshakes and signals completion.
- Tracks whether taps are already loaded, so back-to-back jobs that reuse the same taps skip the reload.
- Sits between the register-file/control slave and the streamer, datapath and tap buffer.

Parameters:
ADDR_WIDTH, 32, width of byte addresses in the job descriptor.
LEN_WIDTH, 16, width of the output-sample count.
NB_TAPS, 50, number of filter taps; sets the tap transfer length and the extra input samples.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
start_i  in  1  job start pulse
reuse_taps_i  in  1  skip tap reload if taps are valid
h_addr_i  in  ADDR_WIDTH  tap base address
x_addr_i  in  ADDR_WIDTH  input base address
y_addr_i  in  ADDR_WIDTH  output base address
len_i  in  LEN_WIDTH  number of output samples
busy_o  out  1  job in progress
done_o  out  1  one-cycle completion pulse
err_o  out  1  one-cycle rejected-start pulse
clear_o  out  1  one-cycle clear to datapath and tap buffer
req_addr_o  out  ADDR_WIDTH  shared request address
req_len_o  out  LEN_WIDTH+1  shared request length, in elements
h_req_valid_o / h_req_ready_i  out/in  1  tap source request handshake
x_req_valid_o / x_req_ready_i  out/in  1  input source request handshake
y_req_valid_o / y_req_ready_i  out/in  1  output sink request handshake
h_done_i, x_done_i, y_done_i  in  1  streamer transfer-complete pulses
taps_full_i  in  1  tap buffer holds NB_TAPS taps
y_hs_i  in  1  output stream valid&ready this cycle
y_count_o  out  LEN_WIDTH  outputs accepted in the current job
taps_valid_o  out  1  taps loaded and reusable

Behaviour:
- Reset (rst_i high at a clock edge, any state, including mid-job):
  - state goes to IDLE; taps_valid_o=0; y_count_o=0.
  - All outputs low: busy_o, done_o, err_o, clear_o, every req_valid.
  - All sticky flags cleared; req_addr_o=0, req_len_o=0.
- Job acceptance:
  - start_i in IDLE with len_i!=0: latch all descriptor inputs; busy_o=1 next cycle.
  - start_i in IDLE with len_i==0: err_o pulses next cycle; stay IDLE.
  - start_i while busy: ignored; err_o pulses next cycle; the current job is unaffected.
  - Descriptor inputs are sampled only at acceptance.
- States:
  - IDLE: on accepted start, go to Y_REQ if reuse_taps_i && taps_valid_o, else CLEAR.
  - CLEAR: clear_o=1 for exactly one cycle; taps_valid_o<=0; y_count_o<=0; go to H_REQ.
  - H_REQ: h_req_valid_o=1, req_addr_o=h_addr, req_len_o=NB_TAPS. On h_req_ready_i go to H_WAIT.
  - H_WAIT: wait until both h_done_i and taps_full_i have been seen. Each is held in a sticky flag, so they may arrive in any order or the same cycle. Then set taps_valid_o<=1 and go to Y_REQ.
  - Y_REQ: y_req_valid_o=1, req_addr_o=y_addr, req_len_o=len. On y_req_ready_i go to X_REQ.
  - X_REQ: x_req_valid_o=1, req_addr_o=x_addr, req_len_o=len+NB_TAPS-1 (computed in LEN_WIDTH+1 bits, no overflow). On x_req_ready_i go to RUN.
  - RUN: y_count_o increments on each y_hs_i. When y_count_o==len and y_done_i has been seen (sticky), go to DONE. x_done_i is recorded but not required for exit.
  - DONE: done_o=1 for one cycle; busy_o drops the following cycle; go to IDLE.
- Reuse path: when taps are reused, CLEAR does not occur, so y_count_o is reset on acceptance instead.
- Request handshakes:
  - At most one req_valid is high at any time.
  - A valid stays high, with req_addr_o and req_len_o stable, until its ready is seen; valid does not depend on ready.
  - A ready arriving in the same cycle valid first rises completes the request.
- Counting:
  - y_hs_i outside RUN is ignored.
  - y_hs_i in the same cycle as the final increment is counted.
  - The count saturates at len; further y_hs_i are ignored.
  - y_count_o holds its value in IDLE until the next job.
- y_done_i is recorded in a sticky flag from Y_REQ onward, since an early completion is legal.
- busy_o=1 in every state except IDLE. Every register update is synchronous to clk_i.

Test Plan:
- Fresh job, len=8, NB_TAPS=50, all readies tied high:
  - clear_o pulses once; then the h, y and x requests issue in that order.
  - Request lengths are 50, 8 and 57.
  - After 8 y_hs_i plus y_done_i: done_o pulses; y_count_o=8; taps_valid_o=1.
- Second job with reuse_taps_i=1: no clear_o and no h request; the y request is issued 1 cycle after busy_o rises.
- h_done_i 5 cycles before taps_full_i, then the reverse order: Y_REQ is entered only after the later of the two in both cases.
- Hold y_req_ready_i low for 10 cycles: y_req_valid_o stays high with req_addr_o stable; x_req_valid_o stays low.
- start_i with len_i=0, and start_i mid-job: err_o pulses each time; the running job completes normally.
- rst_i asserted in RUN after 3 outputs: next cycle busy_o=0, y_count_o=0, taps_valid_o=0 and all req_valids low.

Source files
------------

// File: rtl/fir_job_sequencer.sv
// Control sequencer for one FIR job: latches the descriptor, issues tap/output/input
// streamer requests in order, counts output handshakes and tracks tap reuse.
module fir_job_sequencer #(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int NB_TAPS    = 50
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  reuse_taps_i,
  input  logic [ADDR_WIDTH-1:0] h_addr_i,
  input  logic [ADDR_WIDTH-1:0] x_addr_i,
  input  logic [ADDR_WIDTH-1:0] y_addr_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  clear_o,
  output logic [ADDR_WIDTH-1:0] req_addr_o,
  output logic [LEN_WIDTH:0]    req_len_o,
  output logic                  h_req_valid_o,
  input  logic                  h_req_ready_i,
  output logic                  x_req_valid_o,
  input  logic                  x_req_ready_i,
  output logic                  y_req_valid_o,
  input  logic                  y_req_ready_i,
  input  logic                  h_done_i,
  input  logic                  x_done_i,
  input  logic                  y_done_i,
  input  logic                  taps_full_i,
  input  logic                  y_hs_i,
  output logic [LEN_WIDTH-1:0]  y_count_o,
  output logic                  taps_valid_o
);

  // state  | meaning
  // IDLE   | waiting for an accepted start
  // CLEAR  | one-cycle clear of datapath and tap buffer
  // H_REQ  | tap source request outstanding
  // H_WAIT | waiting for tap transfer done and tap buffer full
  // Y_REQ  | output sink request outstanding
  // X_REQ  | input source request outstanding
  // RUN    | counting output handshakes
  // DONE   | one-cycle completion pulse
  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_H_REQ, S_H_WAIT, S_Y_REQ, S_X_REQ, S_RUN, S_DONE
  } state_t;

  localparam logic [LEN_WIDTH:0] TAP_LEN   = (LEN_WIDTH+1)'(NB_TAPS);
  localparam logic [LEN_WIDTH:0] TAP_EXTRA = (LEN_WIDTH+1)'(NB_TAPS - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] h_addr_q, h_addr_d, x_addr_q, x_addr_d, y_addr_q, y_addr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d, y_count_q, y_count_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [LEN_WIDTH:0]    req_len_q, req_len_d;
  logic busy_q, busy_d, done_q, done_d, err_q, err_d, clear_q, clear_d;
  logic h_valid_q, h_valid_d, x_valid_q, x_valid_d, y_valid_q, y_valid_d;
  logic taps_valid_q, taps_valid_d;
  logic h_done_seen_q, h_done_seen_d, taps_full_seen_q, taps_full_seen_d;
  logic y_done_seen_q, y_done_seen_d, x_done_seen_q, x_done_seen_d;
  logic accept;

  always_comb begin
    state_d          = state_q;
    h_addr_d         = h_addr_q;
    x_addr_d         = x_addr_q;
    y_addr_d         = y_addr_q;
    len_d            = len_q;
    y_count_d        = y_count_q;
    taps_valid_d     = taps_valid_q;
    req_addr_d       = req_addr_q;
    req_len_d        = req_len_q;
    h_done_seen_d    = h_done_seen_q;
    taps_full_seen_d = taps_full_seen_q;
    y_done_seen_d    = y_done_seen_q;
    x_done_seen_d    = x_done_seen_q;

    accept = start_i && (state_q == S_IDLE) && (len_i != '0);
    err_d  = start_i && !accept;

    if (state_q == S_Y_REQ || state_q == S_X_REQ || state_q == S_RUN) begin
      y_done_seen_d = y_done_seen_q | y_done_i;
      x_done_seen_d = x_done_seen_q | x_done_i;
    end
    if (state_q == S_H_WAIT) begin
      h_done_seen_d    = h_done_seen_q | h_done_i;
      taps_full_seen_d = taps_full_seen_q | taps_full_i;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          h_addr_d         = h_addr_i;
          x_addr_d         = x_addr_i;
          y_addr_d         = y_addr_i;
          len_d            = len_i;
          y_count_d        = '0;
          h_done_seen_d    = 1'b0;
          taps_full_seen_d = 1'b0;
          y_done_seen_d    = 1'b0;
          x_done_seen_d    = 1'b0;
          state_d          = (reuse_taps_i && taps_valid_q) ? S_Y_REQ : S_CLEAR;
        end
      end
      S_CLEAR: begin
        taps_valid_d = 1'b0;
        y_count_d    = '0;
        state_d      = S_H_REQ;
      end
      S_H_REQ: begin
        if (h_valid_q && h_req_ready_i) state_d = S_H_WAIT;
      end
      S_H_WAIT: begin
        if ((h_done_seen_q || h_done_i) && (taps_full_seen_q || taps_full_i)) begin
          taps_valid_d = 1'b1;
          state_d      = S_Y_REQ;
        end
      end
      S_Y_REQ: begin
        if (y_valid_q && y_req_ready_i) state_d = S_X_REQ;
      end
      S_X_REQ: begin
        if (x_valid_q && x_req_ready_i) state_d = S_RUN;
      end
      S_RUN: begin
        if (y_hs_i && (y_count_q != len_q)) y_count_d = y_count_q + LEN_WIDTH'(1);
        if ((y_count_q == len_q) && (y_done_seen_q || y_done_i)) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Request valids follow the state with one cycle of setup, so address and
    // length are already stable on the first cycle valid is seen.
    h_valid_d = (state_q == S_H_REQ) && !(h_valid_q && h_req_ready_i);
    y_valid_d = (state_q == S_Y_REQ) && !(y_valid_q && y_req_ready_i);
    x_valid_d = (state_q == S_X_REQ) && !(x_valid_q && x_req_ready_i);

    case (state_q)
      S_H_REQ: begin
        req_addr_d = h_addr_q;
        req_len_d  = TAP_LEN;
      end
      S_Y_REQ: begin
        req_addr_d = y_addr_q;
        req_len_d  = {1'b0, len_q};
      end
      S_X_REQ: begin
        req_addr_d = x_addr_q;
        req_len_d  = {1'b0, len_q} + TAP_EXTRA;
      end
      default: ;
    endcase

    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    clear_d = (state_d == S_CLEAR);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q          <= S_IDLE;
      h_addr_q         <= '0;
      x_addr_q         <= '0;
      y_addr_q         <= '0;
      len_q            <= '0;
      y_count_q        <= '0;
      taps_valid_q     <= 1'b0;
      req_addr_q       <= '0;
      req_len_q        <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      err_q            <= 1'b0;
      clear_q          <= 1'b0;
      h_valid_q        <= 1'b0;
      x_valid_q        <= 1'b0;
      y_valid_q        <= 1'b0;
      h_done_seen_q    <= 1'b0;
      taps_full_seen_q <= 1'b0;
      y_done_seen_q    <= 1'b0;
      x_done_seen_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      h_addr_q         <= h_addr_d;
      x_addr_q         <= x_addr_d;
      y_addr_q         <= y_addr_d;
      len_q            <= len_d;
      y_count_q        <= y_count_d;
      taps_valid_q     <= taps_valid_d;
      req_addr_q       <= req_addr_d;
      req_len_q        <= req_len_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      err_q            <= err_d;
      clear_q          <= clear_d;
      h_valid_q        <= h_valid_d;
      x_valid_q        <= x_valid_d;
      y_valid_q        <= y_valid_d;
      h_done_seen_q    <= h_done_seen_d;
      taps_full_seen_q <= taps_full_seen_d;
      y_done_seen_q    <= y_done_seen_d;
      x_done_seen_q    <= x_done_seen_d;
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign clear_o       = clear_q;
  assign req_addr_o    = req_addr_q;
  assign req_len_o     = req_len_q;
  assign h_req_valid_o = h_valid_q;
  assign x_req_valid_o = x_valid_q;
  assign y_req_valid_o = y_valid_q;
  assign y_count_o     = y_count_q;
  assign taps_valid_o  = taps_valid_q;

endmodule

// File: tb/tb_fir_job_sequencer.sv
// Bench for fir_job_sequencer: a streamer-side driver per scenario plus a request
// scoreboard that checks issue order, address and length of every handshake.
module tb_fir_job_sequencer;
  localparam int AW = 32;
  localparam int LW = 16;
  localparam int NT = 50;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic start_i = 1'b0, reuse_taps_i = 1'b0;
  logic [AW-1:0] h_addr_i = '0, x_addr_i = '0, y_addr_i = '0;
  logic [LW-1:0] len_i = '0;
  logic busy_o, done_o, err_o, clear_o;
  logic [AW-1:0] req_addr_o;
  logic [LW:0] req_len_o;
  logic h_req_valid_o, x_req_valid_o, y_req_valid_o;
  logic h_req_ready_i = 1'b1, x_req_ready_i = 1'b1, y_req_ready_i = 1'b1;
  logic h_done_i = 1'b0, x_done_i = 1'b0, y_done_i = 1'b0;
  logic taps_full_i = 1'b0, y_hs_i = 1'b0;
  logic [LW-1:0] y_count_o;
  logic taps_valid_o;

  fir_job_sequencer #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW), .NB_TAPS(NT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .reuse_taps_i(reuse_taps_i),
    .h_addr_i(h_addr_i), .x_addr_i(x_addr_i), .y_addr_i(y_addr_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .clear_o(clear_o),
    .req_addr_o(req_addr_o), .req_len_o(req_len_o),
    .h_req_valid_o(h_req_valid_o), .h_req_ready_i(h_req_ready_i),
    .x_req_valid_o(x_req_valid_o), .x_req_ready_i(x_req_ready_i),
    .y_req_valid_o(y_req_valid_o), .y_req_ready_i(y_req_ready_i),
    .h_done_i(h_done_i), .x_done_i(x_done_i), .y_done_i(y_done_i),
    .taps_full_i(taps_full_i), .y_hs_i(y_hs_i),
    .y_count_o(y_count_o), .taps_valid_o(taps_valid_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]    kind;   // 0 = tap, 1 = output, 2 = input
    logic [AW-1:0] addr;
    logic [LW:0]   len;
  } req_t;

  req_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   clear_cnt = 0;
  int   done_cnt = 0;
  bit   tb_taps_valid = 0;

  req_t       mon_e;
  logic [1:0] mon_k;
  logic       mon_got;

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (clear_o) clear_cnt++;
      if (done_o) done_cnt++;
      n_checks++;
      if ($countones({h_req_valid_o, y_req_valid_o, x_req_valid_o}) > 1) begin
        n_fail++;
        $display("FAIL onehot_valid: h/y/x valids=%b, required at most one high",
                 {h_req_valid_o, y_req_valid_o, x_req_valid_o});
      end
      mon_got = 1'b1;
      mon_k   = 2'd0;
      if (h_req_valid_o && h_req_ready_i) mon_k = 2'd0;
      else if (y_req_valid_o && y_req_ready_i) mon_k = 2'd1;
      else if (x_req_valid_o && x_req_ready_i) mon_k = 2'd2;
      else mon_got = 1'b0;
      if (mon_got) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected_req: got kind=%0d addr=%h len=%0d, required no request",
                   mon_k, req_addr_o, req_len_o);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_k !== mon_e.kind || req_addr_o !== mon_e.addr || req_len_o !== mon_e.len) begin
            n_fail++;
            $display("FAIL sb_req: got kind=%0d addr=%h len=%0d, required kind=%0d addr=%h len=%0d",
                     mon_k, req_addr_o, req_len_o, mon_e.kind, mon_e.addr, mon_e.len);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic run_job(input logic reuse, input logic [AW-1:0] ha, xa, ya,
                         input logic [LW-1:0] len, input int hd, fd, ystall,
                         input logic inject_err, input logic check_lat);
    int  c0, d0, lim;
    bit  ok, rp;
    rp = reuse && tb_taps_valid;
    if (!rp) exp_q.push_back('{2'd0, ha, (LW+1)'(NT)});
    exp_q.push_back('{2'd1, ya, {1'b0, len}});
    exp_q.push_back('{2'd2, xa, {1'b0, len} + (LW+1)'(NT - 1)});
    if (!rp) taps_full_i = 1'b0;
    y_req_ready_i = (ystall == 0);
    c0 = clear_cnt;
    d0 = done_cnt;

    start_i = 1'b1; reuse_taps_i = reuse;
    h_addr_i = ha; x_addr_i = xa; y_addr_i = ya; len_i = len;
    tick();
    start_i = 1'b0; reuse_taps_i = 1'b0;
    h_addr_i = ~ha; x_addr_i = ~xa; y_addr_i = ~ya; len_i = len + 3;

    if (check_lat) begin
      @(negedge clk_i);
      n_checks++;
      if (busy_o !== 1'b1 || y_req_valid_o !== 1'b0 || y_count_o !== '0) begin
        n_fail++;
        $display("FAIL reuse_accept: busy=%b yvalid=%b ycount=%0d, required 1 0 0",
                 busy_o, y_req_valid_o, y_count_o);
      end
      @(negedge clk_i);
      n_checks++;
      if (y_req_valid_o !== 1'b1) begin
        n_fail++;
        $display("FAIL reuse_y_latency: yvalid=%b one cycle after busy, required 1", y_req_valid_o);
      end
    end

    if (!rp) begin
      ok = 0;
      for (int t = 0; t < 20; t++) begin
        @(negedge clk_i);
        if (h_req_valid_o && h_req_ready_i) begin ok = 1; break; end
      end
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL h_req_timeout: no tap request, required one"); end
      lim = (hd > fd) ? hd : fd;
      for (int i = 0; i <= lim; i++) begin
        tick();
        h_done_i = (i == hd);
        if (i == fd) taps_full_i = 1'b1;
        @(negedge clk_i);
        n_checks++;
        if (y_req_valid_o !== 1'b0) begin
          n_fail++;
          $display("FAIL y_before_taps: yvalid=%b at step %0d, required 0", y_req_valid_o, i);
        end
      end
      tick();
      h_done_i = 1'b0;
    end

    if (ystall > 0) begin
      ok = 0;
      for (int t = 0; t < 20; t++) begin
        @(negedge clk_i);
        if (y_req_valid_o) begin ok = 1; break; end
      end
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL y_req_timeout: no output request, required one"); end
      for (int i = 0; i < ystall; i++) begin
        @(negedge clk_i);
        n_checks++;
        if (y_req_valid_o !== 1'b1 || req_addr_o !== ya || x_req_valid_o !== 1'b0) begin
          n_fail++;
          $display("FAIL y_stall_hold: yvalid=%b addr=%h xvalid=%b, required 1 %h 0",
                   y_req_valid_o, req_addr_o, x_req_valid_o, ya);
        end
      end
      tick();
      y_req_ready_i = 1'b1;
    end

    ok = 0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk_i);
      if (x_req_valid_o && x_req_ready_i) begin ok = 1; break; end
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL x_req_timeout: no input request, required one"); end

    for (int i = 0; i < int'(len) + 2; i++) begin
      tick();
      y_hs_i   = 1'b1;
      y_done_i = (i == 0);
      x_done_i = (i == 1);
      start_i  = inject_err && (i == 2);
      len_i    = 16'd9;
      if (inject_err && i == 3) begin
        @(negedge clk_i);
        n_checks++;
        if (err_o !== 1'b1) begin
          n_fail++;
          $display("FAIL err_mid_job: err=%b, required 1", err_o);
        end
      end
    end
    tick();
    y_hs_i = 1'b0; y_done_i = 1'b0; x_done_i = 1'b0; start_i = 1'b0;

    ok = 0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk_i);
      if (!busy_o) begin ok = 1; break; end
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL job_timeout: busy stuck high, required drop"); end
    n_checks++;
    if (done_cnt - d0 != 1) begin
      n_fail++; $display("FAIL done_pulses: got %0d, required 1", done_cnt - d0);
    end
    n_checks++;
    if (y_count_o !== len) begin
      n_fail++; $display("FAIL y_count: got %0d, required %0d", y_count_o, len);
    end
    n_checks++;
    if (taps_valid_o !== 1'b1) begin
      n_fail++; $display("FAIL taps_valid: got %b, required 1", taps_valid_o);
    end
    n_checks++;
    if (clear_cnt - c0 != (rp ? 0 : 1)) begin
      n_fail++; $display("FAIL clear_pulses: got %0d, required %0d", clear_cnt - c0, rp ? 0 : 1);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL sb_drain: %0d requests not issued, required 0", exp_q.size());
    end
    tb_taps_valid = 1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) tick();
    rst_i = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if ({busy_o, done_o, err_o, clear_o, h_req_valid_o, x_req_valid_o, y_req_valid_o,
         taps_valid_o} !== 8'h00) begin
      n_fail++; $display("FAIL reset_flags: busy..taps_valid=%b, required 0", {busy_o, done_o,
               err_o, clear_o, h_req_valid_o, x_req_valid_o, y_req_valid_o, taps_valid_o});
    end
    n_checks++;
    if (req_addr_o !== '0 || req_len_o !== '0 || y_count_o !== '0) begin
      n_fail++; $display("FAIL reset_regs: addr=%h len=%0d ycount=%0d, required 0 0 0",
                         req_addr_o, req_len_o, y_count_o);
    end
  endtask

  task automatic test_fresh_job();
    run_job(1'b0, 32'h1000_0000, 32'h2000_0000, 32'h3000_0000, 16'd8, 2, 2, 0, 1'b0, 1'b0);
  endtask

  task automatic test_reuse();
    run_job(1'b1, 32'h1000_0100, 32'h2000_0100, 32'h3000_0100, 16'd5, 0, 0, 0, 1'b0, 1'b1);
  endtask

  task automatic test_tap_order();
    run_job(1'b0, 32'h1111_0000, 32'h2222_0000, 32'h3333_0000, 16'd4, 1, 6, 0, 1'b0, 1'b0);
    run_job(1'b0, 32'h1111_0040, 32'h2222_0040, 32'h3333_0040, 16'd4, 6, 1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_stall();
    run_job(1'b1, 32'hAAAA_0000, 32'hBBBB_0000, 32'hCCCC_0000, 16'd3, 0, 0, 10, 1'b0, 1'b0);
  endtask

  task automatic test_err();
    tick();
    start_i = 1'b1;
    len_i   = '0;
    tick();
    start_i = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if (err_o !== 1'b1 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL err_len_zero: err=%b busy=%b, required 1 0", err_o, busy_o);
    end
    @(negedge clk_i);
    n_checks++;
    if (err_o !== 1'b0) begin
      n_fail++; $display("FAIL err_one_cycle: err=%b, required 0", err_o);
    end
    run_job(1'b1, 32'h0BAD_0000, 32'h0BAD_1000, 32'h0BAD_2000, 16'd6, 0, 0, 0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    bit ok;
    exp_q.push_back('{2'd1, 32'h5000_0000, 17'd10});
    exp_q.push_back('{2'd2, 32'h6000_0000, 17'd10 + 17'(NT - 1)});
    start_i = 1'b1; reuse_taps_i = 1'b1; len_i = 16'd10;
    h_addr_i = 32'h4000_0000; x_addr_i = 32'h6000_0000; y_addr_i = 32'h5000_0000;
    tick();
    start_i = 1'b0; reuse_taps_i = 1'b0;
    ok = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk_i);
      if (x_req_valid_o && x_req_ready_i) begin ok = 1; break; end
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rm_x_timeout: no input request, required one"); end
    repeat (3) begin tick(); y_hs_i = 1'b1; end
    tick();
    y_hs_i = 1'b0;
    rst_i  = 1'b1;
    @(negedge clk_i);
    n_checks++;
    if (y_count_o !== 16'd3) begin
      n_fail++; $display("FAIL count_before_reset: got %0d, required 3", y_count_o);
    end
    tick();
    rst_i = 1'b0;
    tb_taps_valid = 0;
    @(negedge clk_i);
    n_checks++;
    if (busy_o !== 1'b0 || y_count_o !== '0 || taps_valid_o !== 1'b0 ||
        {h_req_valid_o, x_req_valid_o, y_req_valid_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_mid_run: busy=%b ycount=%0d taps_valid=%b valids=%b, required 0 0 0 000",
               busy_o, y_count_o, taps_valid_o, {h_req_valid_o, x_req_valid_o, y_req_valid_o});
    end
    run_job(1'b1, 32'h7000_0000, 32'h7100_0000, 32'h7200_0000, 16'd2, 3, 0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_fresh_job();
    test_reuse();
    test_tap_order();
    test_stall();
    test_err();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
